// File: rtl/ks_add_arbiter.sv
// Round-robin front end that shares one fixed-latency pipelined adder among N_REQ
// requesters; a latency-matched tag pipeline steers each result back to its issuer.
module ks_add_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int LAT   = 6
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_hold,
  input  logic [N_REQ-1:0]       i_req_valid,
  output logic [N_REQ-1:0]       o_req_ready,
  input  logic [N_REQ*WIDTH-1:0] i_req_a,
  input  logic [N_REQ*WIDTH-1:0] i_req_b,
  input  logic [N_REQ-1:0]       i_req_cin,
  input  logic [N_REQ-1:0]       i_req_sub,
  output logic                   o_add_valid,
  output logic [WIDTH-1:0]       o_add_a,
  output logic [WIDTH-1:0]       o_add_b,
  output logic                   o_add_cin,
  input  logic [WIDTH-1:0]       i_add_sum,
  input  logic                   i_add_cout,
  output logic [N_REQ-1:0]       o_rsp_valid,
  output logic [WIDTH-1:0]       o_rsp_sum,
  output logic                   o_rsp_cout,
  output logic                   o_busy
);

  localparam int IDW = $clog2(N_REQ);

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   scan_idx;
  logic [IDW-1:0]   grant_id;
  logic             grant_any;

  logic             add_valid_q, add_valid_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic             add_cin_q, add_cin_d;
  logic [IDW-1:0]   add_id_q, add_id_d;

  logic [LAT-1:0]   tag_vld_q, tag_vld_d;
  logic [IDW-1:0]   tag_id_q [LAT];
  logic [IDW-1:0]   tag_id_d [LAT];

  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_cout_q, rsp_cout_d;

  // Scan from the stored pointer; readiness is gated during reset so every output reads 0.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    scan_idx  = '0;
    ptr_d     = ptr_q;
    if (i_rst_n && !i_hold) begin
      for (int i = 0; i < N_REQ; i++) begin
        scan_idx = IDW'((int'(ptr_q) + i) % N_REQ);
        if (!grant_any && i_req_valid[scan_idx]) begin
          grant_any = 1'b1;
          grant_id  = scan_idx;
        end
      end
    end
    if (grant_any) begin
      ptr_d = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + IDW'(1);
    end
  end

  assign o_req_ready = grant_any ? (N_REQ'(1) << grant_id) : '0;

  always_comb begin
    add_valid_d = grant_any;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_cin_d   = add_cin_q;
    add_id_d    = add_id_q;
    if (grant_any) begin
      add_a_d  = i_req_a[int'(grant_id)*WIDTH +: WIDTH];
      add_id_d = grant_id;
      if (i_req_sub[grant_id]) begin
        add_b_d   = ~i_req_b[int'(grant_id)*WIDTH +: WIDTH];
        add_cin_d = 1'b1;
      end else begin
        add_b_d   = i_req_b[int'(grant_id)*WIDTH +: WIDTH];
        add_cin_d = i_req_cin[grant_id];
      end
    end
  end

  // Tag tail lines up with the cycle the adder presents the matching sum.
  always_comb begin
    tag_vld_d[0] = add_valid_q;
    tag_id_d[0]  = add_id_q;
    for (int i = 1; i < LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    if (tag_vld_q[LAT-1]) begin
      rsp_valid_d[tag_id_q[LAT-1]] = 1'b1;
      rsp_sum_d                    = i_add_sum;
      rsp_cout_d                   = i_add_cout;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q       <= '0;
      add_valid_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      add_id_q    <= '0;
      tag_vld_q   <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_id_q[i] <= '0;
      end
      rsp_valid_q <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      add_valid_q <= add_valid_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      add_id_q    <= add_id_d;
      tag_vld_q   <= tag_vld_d;
      for (int i = 0; i < LAT; i++) begin
        tag_id_q[i] <= tag_id_d[i];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
    end
  end

  assign o_add_valid = add_valid_q;
  assign o_add_a     = add_a_q;
  assign o_add_b     = add_b_q;
  assign o_add_cin   = add_cin_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_sum   = rsp_sum_q;
  assign o_rsp_cout  = rsp_cout_q;
  assign o_busy      = add_valid_q | (|tag_vld_q) | (|rsp_valid_q);

endmodule
